// File: rtl/alu_mul_seq.sv
// Sequential 16x16 shift-add multiplier that performs all arithmetic on an external ALU.
// Optional build macro MUL_EARLY_EXIT_EN: finish as soon as the shifted multiplier reaches zero.

package alu_mul_seq_pkg;
    typedef enum logic [3:0] {
        F_A         = 4'h0,
        F_A_PLUS_B  = 4'h1,
        F_A_MINUS_B = 4'h2,
        F_A_AND_B   = 4'h3,
        F_A_OR_B    = 4'h4,
        F_A_XOR_B   = 4'h5,
        F_A_SHL     = 4'h6,
        F_A_LSHR    = 4'h7,
        F_A_ASHR    = 4'h8
    } alu_op_t;
endpackage

module alu_mul_seq
    import alu_mul_seq_pkg::*;
(
    input  logic        clock,
    input  logic        reset_L,
    input  logic        start,
    output logic        ready,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic [15:0] product,
    output logic        ovf,
    output logic        done,
    output alu_op_t     alu_opcode,
    output logic [15:0] alu_inA,
    output logic [15:0] alu_inB,
    input  logic [15:0] alu_out,
    input  logic [3:0]  alu_cc
);

    // state | meaning
    // IDLE  | waiting for start, ready=1
    // ADD   | P <= P + A when B[0]=1, else P passes through
    // SHL   | A <= A << 1, remember any bit shifted out
    // SHR   | B <= B >> 1, count the iteration
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHL,
        S_SHR,
        S_DONE
    } state_t;

    localparam int CC_Z = 3;
    localparam int CC_C = 2;

    state_t      state;
    logic [15:0] reg_a;
    logic [15:0] reg_b;
    logic [15:0] reg_p;
    logic        lost_a;
    logic [4:0]  cnt;
    logic [4:0]  cnt_next;
    logic        last_iter;
    logic        unused_cc;

    assign product   = reg_p;
    assign cnt_next  = cnt + 5'd1;
    assign unused_cc = ^alu_cc;

`ifdef MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_next == 5'd16) || alu_cc[CC_Z];
`else
    assign last_iter = (cnt_next == 5'd16);
`endif

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state  <= S_IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            reg_a  <= '0;
            reg_b  <= '0;
            reg_p  <= '0;
            ovf    <= 1'b0;
            lost_a <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        reg_a  <= mcand;
                        reg_b  <= mplier;
                        reg_p  <= '0;
                        lost_a <= 1'b0;
                        ovf    <= 1'b0;
                        cnt    <= '0;
                        ready  <= 1'b0;
                        state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    reg_p <= alu_out;
                    // An add after a lost multiplicand bit is a product bit >= 2^16.
                    if (reg_b[0] && (alu_cc[CC_C] || lost_a)) begin
                        ovf <= 1'b1;
                    end
                    state <= S_SHL;
                end
                S_SHL: begin
                    reg_a <= alu_out;
                    if (alu_cc[CC_C]) begin
                        lost_a <= 1'b1;
                    end
                    state <= S_SHR;
                end
                S_SHR: begin
                    reg_b <= alu_out;
                    cnt   <= cnt_next;
                    if (last_iter) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_ADD;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ALU drive must be combinational so the result can be captured in the same state.
    always_comb begin
        alu_opcode = F_A;
        alu_inA    = '0;
        alu_inB    = '0;
        case (state)
            S_ADD: begin
                alu_inA = reg_p;
                if (reg_b[0]) begin
                    alu_opcode = F_A_PLUS_B;
                    alu_inB    = reg_a;
                end
            end
            S_SHL: begin
                alu_opcode = F_A_SHL;
                alu_inA    = reg_a;
            end
            S_SHR: begin
                alu_opcode = F_A_LSHR;
                alu_inA    = reg_b;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 Parameters: none; the datapath width is fixed at 16 bits to match the ALU port widths.
REQ-002 clock  in  1  the single clock; all state changes on its rising edge.
REQ-003 reset_L  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  requests a multiply; accepted only when ready=1.
REQ-005 ready  out  1  high only in IDLE.
REQ-006 mcand, mplier  in  16 each  unsigned multiplicand and multiplier, sampled on the accepting edge.
REQ-007 product  out  16  low 16 bits of mcand*mplier.
REQ-008 ovf  out  1  high when the true unsigned product is at least 2^16.
REQ-009 done  out  1  one-cycle pulse; product and ovf are valid from this cycle onward.
REQ-010 alu_opcode  out  alu_op_t  opcode driven to the external ALU instance.
REQ-011 alu_inA, alu_inB  out  16 each  ALU operands.
REQ-012 alu_out  in  16  ALU result, combinational from this block's drive.
REQ-013 alu_cc  in  4  ALU condition codes in {Z,C,N,V} order.

Function
REQ-014 All arithmetic SHALL be performed by the external ALU; this block adds no adders or shifters on data, only registers, muxes and a 5-bit iteration counter.
REQ-015 States: IDLE, ADD, SHL, SHR, DONE, each lasting exactly one cycle.
REQ-016 IDLE: when start=1, load A=mcand, B=mplier, P=0, lostA=0, ovf=0 and cnt=0, then go to ADD; otherwise stay in IDLE.
REQ-017 ADD: if B[0]=1, drive F_A_PLUS_B with inA=P and inB=A; otherwise drive F_A with inA=P.
REQ-018 ADD: P <= alu_out; if B[0]=1 and (alu_cc C=1 or lostA=1), set ovf (sticky); next state is SHL.
REQ-019 SHL: drive F_A_SHL with inA=A and inB=0; A <= alu_out; if alu_cc C=1, set lostA (sticky); next state is SHR.
REQ-020 SHR: drive F_A_LSHR with inA=B and inB=0; B <= alu_out; cnt <= cnt+1.
REQ-021 SHR: go to DONE when cnt+1=16 (or on early exit, see Configuration); otherwise go to ADD.
REQ-022 DONE: assert done=1 and ready=0; next state is IDLE.
REQ-023 product SHALL reflect P at all times; product and ovf SHALL hold their values until the next start is accepted.
REQ-024 In IDLE and DONE, drive alu_opcode=F_A and alu_inA=alu_inB=0.
REQ-025 start while busy (ready=0) SHALL be ignored, and operand changes while busy SHALL have no effect.
REQ-026 Latency without early exit: start accepted at edge k, so done is high in the cycle after edge k+48; a new start is accepted in the cycle after DONE at the earliest.
REQ-027 lostA records that a set bit of A shifted out; any later add then overflows, which makes ovf exact for unsigned operands.

Reset
REQ-028 reset_L=0 SHALL immediately force state=IDLE, ready=1, done=0, product=0, ovf=0, A=B=0, cnt=0, lostA=0.
REQ-029 Reset asserted mid-operation SHALL abort the operation with no done pulse; the next start after reset is accepted normally.

Configuration
REQ-030 Macro MUL_EARLY_EXIT_EN, when defined: SHR also goes to DONE when the SHR result has alu_cc Z=1; latency is 3*(index of the highest set mplier bit + 1) cycles plus DONE (mplier=0 gives one iteration).
REQ-031 When MUL_EARLY_EXIT_EN is undefined, exactly 16 iterations always run and the latency is fixed per REQ-026.

Verification
REQ-032 mcand=3, mplier=5 -> product=0x000F, ovf=0, done 1 cycle; no macro: done in cycle 49 after accept; macro: done in cycle 10.
REQ-033 mcand=0xFFFF, mplier=2 -> product=0xFFFE, ovf=1.
REQ-034 mcand=0x0100, mplier=0x0100 -> product=0x0000, ovf=1; mcand=0x00FF, mplier=0x0101 -> product=0xFFFF, ovf=0.
REQ-035 mcand=7, mplier=0 -> product=0, ovf=0; macro: done in cycle 4 after accept.
REQ-036 Start 3*5, pulse start with mcand=9 at cycle 5, assert reset_L=0 at cycle 20 -> 9 ignored, outputs reset immediately, no done; then 2*2 after reset -> product=4.
REQ-037 Every cycle: check alu_opcode, alu_inA and alu_inB against REQ-017/019/020/024; check ready=1 only in IDLE.
